// File: rtl/alu_exec_unit.sv
// Valid/ready ALU execution unit with iterative shifts and registered result/flags {ZF,CF,OF,SF}.
// Define ALU_MUL_EN to build the sequential shift-add multiplier for opcode B; otherwise B is illegal.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef ALU_MUL_EN
    localparam logic [1:0] S_MUL   = 2'd2;
`endif
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [OPW-1:0] OP_AND  = OPW'(0);
    localparam logic [OPW-1:0] OP_OR   = OPW'(1);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(2);
    localparam logic [OPW-1:0] OP_NOR  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(6);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(7);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(8);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(9);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(10);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(11);

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [1:0]       sh_kind;

    logic [SW-1:0]    shamt;
    logic             is_shift;
    logic             use_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             add_of;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cf;
    logic             alu_of;
    logic             alu_err;
    logic [3:0]       alu_flags;
    logic [WIDTH-1:0] sh_val;
    logic             sh_cf;

    assign shamt     = b[SW-1:0];
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign is_shift  = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

    // One shared adder: SUB, SLT and SLTU all evaluate a + ~b + 1.
    always_comb begin
        use_sub   = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
        b_eff     = use_sub ? ~b : b;
        sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, use_sub};
        add_of    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        alu_res   = '0;
        alu_cf    = 1'b0;
        alu_of    = 1'b0;
        alu_err   = 1'b0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_cf  = sum[WIDTH];
                alu_of  = add_of;
            end
            OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_cf  = ~sum[WIDTH];
                alu_of  = add_of;
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_of};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
            OP_SLL, OP_SRL, OP_SRA: alu_res = a;
`ifdef ALU_MUL_EN
            OP_MUL:  alu_res = '0;
`endif
            default: alu_err = 1'b1;
        endcase
        alu_flags = alu_err ? 4'b0000
                            : {alu_res == '0, alu_cf, alu_of, alu_res[WIDTH-1]};
    end

    always_comb begin
        case (sh_kind)
            2'd0: begin
                sh_val = {acc[WIDTH-2:0], 1'b0};
                sh_cf  = acc[WIDTH-1];
            end
            2'd1: begin
                sh_val = {1'b0, acc[WIDTH-1:1]};
                sh_cf  = acc[0];
            end
            default: begin
                sh_val = {acc[WIDTH-1], acc[WIDTH-1:1]};
                sh_cf  = acc[0];
            end
        endcase
    end

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;
    logic             mul_hi_nz;

    // acc holds the low product half; multiplier bits are consumed from its LSB.
    always_comb begin
        mul_sum     = {1'b0, mul_hi} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], acc[WIDTH-1:1]};
        mul_hi_nz   = (mul_hi_next != '0);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            cnt     <= '0;
            sh_kind <= 2'd0;
            result  <= '0;
            flags   <= 4'b0000;
            err     <= 1'b0;
`ifdef ALU_MUL_EN
            mul_hi  <= '0;
            mcand   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_shift && (shamt != '0)) begin
                            acc     <= a;
                            cnt     <= {1'b0, shamt};
                            sh_kind <= op[1:0];
                            state   <= S_SHIFT;
`ifdef ALU_MUL_EN
                        end else if (op == OP_MUL) begin
                            acc    <= b;
                            mcand  <= a;
                            mul_hi <= '0;
                            cnt    <= CW'(WIDTH);
                            state  <= S_MUL;
`endif
                        end else begin
                            result <= alu_res;
                            flags  <= alu_flags;
                            err    <= alu_err;
                            state  <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    acc <= sh_val;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result <= sh_val;
                        flags  <= {sh_val == '0, sh_cf, 1'b0, sh_val[WIDTH-1]};
                        err    <= 1'b0;
                        state  <= S_DONE;
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    acc    <= mul_lo_next;
                    mul_hi <= mul_hi_next;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result <= mul_lo_next;
                        flags  <= {mul_lo_next == '0, mul_hi_nz, mul_hi_nz, mul_lo_next[WIDTH-1]};
                        err    <= 1'b0;
                        state  <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (WIDTH=32); expectations come from a behavioural model or
// from hand-derived constants, and also follow ALU_MUL_EN for opcode B.
module tb_alu_exec_unit;
    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic [3:0]        op = 4'h0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  result;
    logic [3:0]        flags;
    logic              err;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        err;
        int          latency;
    } exp_t;

    exp_t exp_q[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(WIDTH), .OPW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour written from the opcode definitions, not from the datapath structure.
    function automatic exp_t model(input logic [3:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
        exp_t        e;
        logic [32:0] s;
        logic [63:0] p;
        int          sh;
        logic        cf;
        logic        of;
        sh = int'(b_i[4:0]);
        e.result = '0; e.err = 1'b0; e.latency = 1; cf = 1'b0; of = 1'b0; p = '0; s = '0;
        case (op_i)
            4'h0: e.result = a_i & b_i;
            4'h1: e.result = a_i | b_i;
            4'h2: e.result = a_i ^ b_i;
            4'h3: e.result = ~(a_i | b_i);
            4'h4: begin
                s = {1'b0, a_i} + {1'b0, b_i};
                e.result = s[31:0];
                cf = s[32];
                s = {a_i[31], a_i} + {b_i[31], b_i};
                of = s[32] ^ s[31];
            end
            4'h5: begin
                e.result = a_i - b_i;
                cf = (a_i < b_i);
                s = {a_i[31], a_i} - {b_i[31], b_i};
                of = s[32] ^ s[31];
            end
            4'h6: e.result = ($signed(a_i) < $signed(b_i)) ? 32'd1 : 32'd0;
            4'h7: e.result = (a_i < b_i) ? 32'd1 : 32'd0;
            4'h8: begin
                e.result = a_i << sh;
                if (sh != 0) cf = a_i[32-sh];
                e.latency = sh + 1;
            end
            4'h9: begin
                e.result = a_i >> sh;
                if (sh != 0) cf = a_i[sh-1];
                e.latency = sh + 1;
            end
            4'hA: begin
                e.result = 32'($signed(a_i) >>> sh);
                if (sh != 0) cf = a_i[sh-1];
                e.latency = sh + 1;
            end
`ifdef ALU_MUL_EN
            4'hB: begin
                p = {32'b0, a_i} * {32'b0, b_i};
                e.result = p[31:0];
                cf = (p[63:32] != 0);
                of = cf;
                e.latency = WIDTH + 1;
            end
`endif
            default: e.err = 1'b1;
        endcase
        e.flags = e.err ? 4'b0000 : {e.result == 0, cf, of, e.result[31]};
        return e;
    endfunction

    // Called #1 after a clock edge; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i, input exp_t e);
        int waited = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) checkOutput("issue_timeout", 64'd0, 64'd1);
        a = a_i; b = b_i; op = op_i; in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collectResult(input string tag);
        int   cycles = 0;
        exp_t e;
        while (!out_valid && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        if (!out_valid) begin
            checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        checkOutput({tag, "_result"},  64'(result), 64'(e.result));
        checkOutput({tag, "_flags"},   64'(flags),  64'(e.flags));
        checkOutput({tag, "_err"},     64'(err),    64'(e.err));
        checkOutput({tag, "_latency"}, 64'(cycles + 1), 64'(e.latency));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic runDirected(input string tag, input logic [3:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                               input logic [31:0] r, input logic [3:0] f, input logic e_err, input int lat);
        exp_t e;
        e.result = r; e.flags = f; e.err = e_err; e.latency = lat;
        applyStimulus(op_i, a_i, b_i, e);
        collectResult(tag);
        handshake();
    endtask

    task automatic runModel(input string tag, input logic [3:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
        applyStimulus(op_i, a_i, b_i, model(op_i, a_i, b_i));
        collectResult(tag);
        handshake();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic saw_valid;
        exp_t bp;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_result", 64'(result), 64'd0);
        checkOutput("rst_flags", 64'(flags), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        runDirected("add_wrap", 4'h4, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1100, 1'b0, 1);
        runDirected("sub_ovf", 4'h5, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0010, 1'b0, 1);
        runDirected("sub_neg", 4'h5, 32'h1, 32'h2, 32'hFFFFFFFF, 4'b0101, 1'b0, 1);
        runDirected("sra4", 4'hA, 32'h80000000, 32'h4, 32'hF8000000, 4'b0001, 1'b0, 5);
        runDirected("sra_hi_b", 4'hA, 32'h80000000, 32'h24, 32'hF8000000, 4'b0001, 1'b0, 5);
        runDirected("sll0", 4'h8, 32'h1, 32'h0, 32'h1, 4'b0000, 1'b0, 1);
        runDirected("sll1", 4'h8, 32'h80000001, 32'h1, 32'h2, 4'b0100, 1'b0, 2);
        runDirected("srl31", 4'h9, 32'h80000000, 32'd31, 32'h1, 4'b0000, 1'b0, 32);
        runDirected("and", 4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0001, 1'b0, 1);
        runDirected("nor", 4'h3, 32'h0, 32'h0, 32'hFFFFFFFF, 4'b0001, 1'b0, 1);
        runDirected("slt", 4'h6, 32'h80000000, 32'h1, 32'h1, 4'b0000, 1'b0, 1);
        runDirected("sltu", 4'h7, 32'h80000000, 32'h1, 32'h0, 4'b1000, 1'b0, 1);
        runDirected("illegal_c", 4'hC, 32'h5, 32'h5, 32'h0, 4'b0000, 1'b1, 1);
`ifdef ALU_MUL_EN
        runDirected("mul", 4'hB, 32'h10000, 32'h10000, 32'h0, 4'b1110, 1'b0, 33);
`else
        runDirected("mul_off", 4'hB, 32'h10000, 32'h10000, 32'h0, 4'b0000, 1'b1, 1);
`endif

        for (int i = 0; i < 30; i++) begin
            runModel($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), $urandom, $urandom);
        end

        // Backpressure: inputs wiggle while the result is held.
        out_ready = 1'b0;
        bp.result = 32'd12; bp.flags = 4'b0000; bp.err = 1'b0; bp.latency = 1;
        applyStimulus(4'h4, 32'd5, 32'd7, bp);
        collectResult("bp");
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15)); in_valid = ~in_valid;
            @(posedge clk); #1;
            checkOutput($sformatf("bp_hold_result%0d", i), 64'(result), 64'd12);
            checkOutput($sformatf("bp_hold_flags%0d", i), 64'(flags), 64'd0);
            checkOutput($sformatf("bp_in_ready%0d", i), 64'(in_ready), 64'd0);
            checkOutput($sformatf("bp_out_valid%0d", i), 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
        checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of a long shift aborts it.
        applyStimulus(4'h9, 32'hFFFFFFFF, 32'd20, model(4'h9, 32'hFFFFFFFF, 32'd20));
        exp_q.delete(exp_q.size() - 1);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_result", 64'(result), 64'd0);
        checkOutput("abort_flags", 64'(flags), 64'd0);
        checkOutput("abort_err", 64'(err), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        saw_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("abort_no_partial", 64'(saw_valid), 64'd0);
        runModel("after_reset_srl", 4'h9, 32'hFFFFFFFF, 32'd20);
        runModel("after_reset_add", 4'h4, 32'h7FFFFFFF, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
